mod6_sequence_checker: RTL and testbench
========================================

# mod6_sequence_checker

Receive-side checker for the 4-bit mod-6 count stream (0,1,2,3,4,5,0,…) produced by the sequence generator. Each valid sample is compared against the predicted next value. The block acquires lock after a configurable run of correct transitions, flags every mismatch while locked, and keeps a saturating error count. It sits downstream of the generator, in the self-checking harness and in any consumer that must trust the count.

## Interface
- MODULUS, 6: sequence length; legal values are 0..MODULUS-1.
- WIDTH, 4: sample width.
- LOCK_RUN, 3: consecutive correct transitions needed to lock (≥1).
- ERR_W, 8: error counter width.

Ports:
- clock  in  1  rising-edge clock; the single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- valid  in  1  count_in is a sample this cycle.
- count_in  in  WIDTH  received count value.
- locked  out  1  checker is in LOCKED.
- error  out  1  one-cycle pulse on a mismatch while locked.
- expected  out  WIDTH  predicted value of the next sample.
- err_count  out  ERR_W  saturating mismatch count.

## Operation
- Successor: next(v) = (v == MODULUS-1) ? 0 : v+1, computed at WIDTH bits. A sample is out-of-range if v ≥ MODULUS.
- States are HUNT, SYNC and LOCKED; a run counter is sized for LOCK_RUN.
- valid=0: state, expected, run and err_count all hold; error=0.
- HUNT:
  - In-range sample v: expected←next(v), run←0, go to SYNC.
  - Out-of-range sample: stay in HUNT.
- SYNC:
  - v==expected: expected←next(v), run←run+1. If run+1==LOCK_RUN, go to LOCKED.
  - Mismatch with in-range v: reseed with expected←next(v), run←0, stay in SYNC.
  - Mismatch with out-of-range v: go to HUNT.
  - SYNC mismatches never pulse error and never count.
- LOCKED:
  - v==expected: expected←next(v).
  - Mismatch: error pulses and err_count increments, saturating at 2^ERR_W-1. The state then drops to SYNC, reseeded from v, or to HUNT if v is out of range.
- Reset mid-stream: everything returns to reset values immediately; the next valid sample is treated as a HUNT seed.

## Timing
- Reset values: locked=0, error=0, expected=0, err_count=0, state=HUNT, run=0.
- All outputs are registered. Each response appears on the rising edge that samples the input.
  - error is high for exactly the one cycle following the edge that captured the mismatching sample.
  - locked rises on the edge that samples the LOCK_RUN-th correct transition. It falls on the edge that samples the mismatch that drops lock.
- With the generator feeding one sample per cycle from 0, locked rises on the 4th sample edge (the sample with value 3) when LOCK_RUN=3.
- Samples may be gapped by valid=0 for any number of cycles without affecting lock.
- Wrap-around 5→0 is a correct transition.
- err_count at its maximum stays at its maximum; error still pulses.

## Configuration
- MOD6_CHK_FLYWHEEL_EN defined:
  - A single isolated mismatch in LOCKED pulses error and counts, but lock is kept and expected←next(expected); the checker free-runs.
  - A second consecutive mismatch pulses error, counts again, and drops lock as in the normal path.
  - A correct sample clears the miss flag.
- MOD6_CHK_FLYWHEEL_EN undefined: any mismatch in LOCKED drops lock. No miss flag is implemented.

## Structure
- Package mod6_chk_pkg holds:
  - the state enum (HUNT, SYNC, LOCKED);
  - default MODULUS, WIDTH and LOCK_RUN constants;
  - the next-count function.
- Sub-module mod_successor is the combinational next(v) and range check, shared with the generator-side model.
- The checker top holds the FSM, the run counter and the error counter.

## Test plan
- Reset, then stream 0,1,2,3,4,5,0,… every cycle → locked rises at the sample of value 3; error stays 0 for 30 samples; err_count=0.
- Once locked, inject 4 in place of 2 (…,1,4,5,…) → error pulses once, err_count=1, locked drops. Relock occurs 3 samples after the reseed on value 4.
- Inject out-of-range 9 while locked → error pulses, state goes to HUNT, locked=0; the next sample 0 seeds SYNC.
- Send gapped valid (one sample every 3 cycles) across the 5→0 wrap → lock is held; expected is 0 after a 5 sample.
- Use ERR_W=2 with 5 mismatches while locked → err_count saturates at 3; error pulses 5 times.
- With MOD6_CHK_FLYWHEEL_EN defined, while locked send a single bad sample, then correct samples → error pulses once and locked stays 1. Two consecutive bad samples → locked drops.

Source files
------------

// File: rtl/mod6_sequence_checker_pkg.sv
// mod6_chk_pkg: shared states, default parameters and the successor function for the mod-6 checker.
package mod6_chk_pkg;
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
    localparam int DEF_MODULUS = 6;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_LOCK_RUN = 3;
    localparam int DEF_ERR_W = 8;
    function automatic int next_count(input int v, input int modulus);
        return (v == modulus - 1) ? 0 : v + 1;
    endfunction
endpackage

// File: rtl/mod6_sequence_checker_if.sv
// mod6_sequence_checker_if: sample stream in, lock/error status out.
interface mod6_sequence_checker_if
    import mod6_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
);
    logic valid;
    logic [WIDTH-1:0] count_in;
    logic locked;
    logic error;
    logic [WIDTH-1:0] expected;
    logic [ERR_W-1:0] err_count;
    modport master(output valid, count_in, input locked, error, expected, err_count);
    modport slave(input valid, count_in, output locked, error, expected, err_count);
endinterface

// File: rtl/mod6_sequence_checker_successor.sv
// mod_successor: combinational next(v) and range check for a mod-MODULUS count.
module mod_successor
    import mod6_chk_pkg::*;
#(
    parameter int MODULUS = DEF_MODULUS,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] next,
    output logic             in_range
);
    assign next = WIDTH'(next_count(int'(v), MODULUS));
    assign in_range = int'(v) < MODULUS;
endmodule

// File: rtl/mod6_sequence_checker.sv
// mod6_sequence_checker: acquires lock on a mod-MODULUS count stream and flags/counts mismatches.
// Define MOD6_CHK_FLYWHEEL_EN to tolerate one isolated miss while locked.
module mod6_sequence_checker
    import mod6_chk_pkg::*;
#(
    parameter int MODULUS = DEF_MODULUS,
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOCK_RUN = DEF_LOCK_RUN,
    parameter int ERR_W = DEF_ERR_W
) (
    input logic clock,
    input logic reset_n,
    mod6_sequence_checker_if.slave bus
);
    localparam int RUN_W = $clog2(LOCK_RUN + 1);
    state_t state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d, seed;
    logic [RUN_W-1:0] run_q, run_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic error_q, error_d, in_range, match;
`ifdef MOD6_CHK_FLYWHEEL_EN
    logic miss_q, miss_d;
`endif
    mod_successor #(.MODULUS(MODULUS), .WIDTH(WIDTH)) u_succ (
        .v(bus.count_in),
        .next(seed),
        .in_range(in_range)
    );
    assign match = bus.count_in == exp_q;
    always_comb begin
        state_d = state_q;
        exp_d = exp_q;
        run_d = run_q;
        err_d = err_q;
        error_d = 1'b0;
`ifdef MOD6_CHK_FLYWHEEL_EN
        miss_d = miss_q;
`endif
        if (bus.valid) begin
            case (state_q)
                HUNT: if (in_range) begin
                    exp_d = seed;
                    run_d = '0;
                    state_d = SYNC;
                end
                SYNC: begin
                    run_d = match ? run_q + 1'b1 : '0;
                    exp_d = (match || in_range) ? seed : exp_q;
                    state_d = match ? ((run_d == RUN_W'(LOCK_RUN)) ? LOCKED : SYNC) : (in_range ? SYNC : HUNT);
                end
                LOCKED: if (match) begin
                    exp_d = seed;
`ifdef MOD6_CHK_FLYWHEEL_EN
                    miss_d = 1'b0;
`endif
                end else begin
                    error_d = 1'b1;
                    err_d = (&err_q) ? err_q : err_q + 1'b1;
`ifdef MOD6_CHK_FLYWHEEL_EN
                    // first miss free-runs the prediction; a second in a row drops lock
                    if (!miss_q) begin
                        miss_d = 1'b1;
                        exp_d = WIDTH'(next_count(int'(exp_q), MODULUS));
                    end else begin
                        miss_d = 1'b0;
`else
                    begin
`endif
                        state_d = in_range ? SYNC : HUNT;
                        exp_d = in_range ? seed : exp_q;
                        run_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HUNT;
            exp_q <= '0;
            run_q <= '0;
            err_q <= '0;
            error_q <= 1'b0;
`ifdef MOD6_CHK_FLYWHEEL_EN
            miss_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            exp_q <= exp_d;
            run_q <= run_d;
            err_q <= err_d;
            error_q <= error_d;
`ifdef MOD6_CHK_FLYWHEEL_EN
            miss_q <= miss_d;
`endif
        end
    end
    assign bus.locked = state_q == LOCKED;
    assign bus.error = error_q;
    assign bus.expected = exp_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_mod6_sequence_checker.sv
// tb_mod6_sequence_checker: directed + random stream against a sample-level reference model.
module tb_mod6_sequence_checker;
    localparam int M = 6;
    localparam int ERR_W = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int gen, pulses, bad;
    int m_mode, m_exp, m_run, m_err;
    bit m_error, m_miss;
    mod6_sequence_checker_if #(.WIDTH(4), .ERR_W(ERR_W)) bus ();
    mod6_sequence_checker #(.MODULUS(M), .WIDTH(4), .LOCK_RUN(3), .ERR_W(ERR_W)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );
    always #5 clock = ~clock;
    function automatic int succ(input int v);
        return (v + 1) % M;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_mode = 0; m_exp = 0; m_run = 0; m_err = 0; m_error = 0; m_miss = 0;
    endtask
    // mode 0 = hunting, 1 = synchronising, 2 = locked
    task automatic model(input bit vld, input int v);
        bit drop;
        m_error = 0;
        drop = 0;
        if (!vld) return;
        if (m_mode == 0) begin
            if (v < M) begin m_exp = succ(v); m_run = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (v == m_exp) begin
                m_exp = succ(v); m_run++;
                if (m_run == 3) m_mode = 2;
            end else if (v < M) begin
                m_exp = succ(v); m_run = 0;
            end else m_mode = 0;
        end else if (v == m_exp) begin
            m_exp = succ(v); m_miss = 0;
        end else begin
            m_error = 1;
            m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
`ifdef MOD6_CHK_FLYWHEEL_EN
            if (!m_miss) begin m_miss = 1; m_exp = succ(m_exp); end
            else begin m_miss = 0; drop = 1; end
`else
            drop = 1;
`endif
            if (drop) begin
                if (v < M) begin m_mode = 1; m_exp = succ(v); m_run = 0; end
                else m_mode = 0;
            end
        end
    endtask
    task automatic compare_all();
        chk("locked", 32'(bus.locked), 32'(m_mode == 2));
        chk("error", 32'(bus.error), 32'(m_error));
        chk("expected", 32'(bus.expected), 32'(m_exp));
        chk("err_count", 32'(bus.err_count), 32'(m_err));
    endtask
    task automatic step(input bit vld, input int v);
        @(negedge clock);
        bus.valid = vld;
        bus.count_in = 4'(v);
        @(posedge clock);
        model(vld, v);
        #1;
        compare_all();
    endtask
    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, gen);
            gen = succ(gen);
        end
    endtask
    task automatic do_reset();
        @(negedge clock);
        bus.valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask
    initial begin
        bus.valid = 1'b0;
        bus.count_in = '0;
        model_reset();
        #12;
        compare_all();
        reset_n = 1'b1;
        gen = 0;
        feed(3);
        chk("not_locked_before_3", 32'(bus.locked), 32'd0);
        feed(1);
        chk("locked_at_3", 32'(bus.locked), 32'd1);
        feed(26);
        chk("no_errors_clean", 32'(bus.err_count), 32'd0);
        feed(2);
        step(1'b1, 4);
        chk("inject_error", 32'(bus.error), 32'd1);
        chk("inject_count", 32'(bus.err_count), 32'd1);
`ifdef MOD6_CHK_FLYWHEEL_EN
        chk("inject_flywheel_keeps", 32'(bus.locked), 32'd1);
`else
        chk("inject_drops", 32'(bus.locked), 32'd0);
`endif
        gen = 5;
        feed(12);
        chk("relocked", 32'(bus.locked), 32'd1);
        step(1'b1, 9);
        chk("oor_error", 32'(bus.error), 32'd1);
        gen = 0;
        feed(8);
        chk("relock_after_oor", 32'(bus.locked), 32'd1);
        feed(2);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, gen);
            gen = succ(gen);
            step(1'b0, $urandom_range(0, 15));
            step(1'b0, $urandom_range(0, 15));
            if (k == 1) chk("gap_wrap_expected", 32'(bus.expected), 32'd0);
        end
        chk("gap_lock_held", 32'(bus.locked), 32'd1);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            bad = (gen + 3) % M;
            step(1'b1, bad);
            pulses += int'(bus.error);
`ifdef MOD6_CHK_FLYWHEEL_EN
            gen = succ(gen);
`else
            gen = succ(bad);
`endif
            feed(4);
        end
        chk("sat_pulses", 32'(pulses), 32'd5);
        chk("sat_count", 32'(bus.err_count), 32'(ERR_MAX));
        step(1'b1, (gen + 2) % M);
        gen = (gen + 3) % M;
        feed(6);
        step(1'b1, 9);
        step(1'b1, 9);
        chk("double_miss_drops", 32'(bus.locked), 32'd0);
        gen = 0;
        feed(5);
        do_reset();
        for (int i = 0; i < 800; i++) begin
            int r, v;
            bit vld;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
                continue;
            end
            vld = r >= 15;
            v = (r < 24) ? int'($urandom_range(0, 15)) : gen;
            step(vld, v);
            if (vld && r >= 24) gen = succ(gen);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
